// File: rtl/pkt_frame_assembler.sv
// Packs a stream of narrow packets into one wide buffer word (first packet in the
// most-significant slot) and hands the frame downstream with a valid/ready handshake.
module pkt_frame_assembler #(
    parameter  int PKT_W    = 4,
    parameter  int MAX_PKTS = 4,
    parameter  int CNT_W    = 8,
    localparam int BUF_W    = PKT_W * MAX_PKTS,
    localparam int CW       = $clog2(MAX_PKTS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [PKT_W-1:0] pkt_data,
    input  logic             pkt_last,
    output logic             pkt_ready,
    output logic             buf_valid,
    output logic [BUF_W-1:0] buf_data,
    output logic [CW-1:0]    buf_count,
    output logic             buf_trunc,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] slot_idx;
    logic          accept;
    logic          close;
    logic          handshake;

    // Both handshake outputs decode the state register only, so no input reaches an output.
    assign pkt_ready = (state == COLLECT);
    assign buf_valid = (state == HOLD);

    assign accept    = pkt_valid && pkt_ready;
    assign close     = accept && (pkt_last || (slot_idx == CW'(MAX_PKTS - 1)));
    assign handshake = buf_valid && out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (close)     state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = COLLECT;
            default:                state_nxt = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    // NOTE: the frame buffer is a handful of flops, not a RAM, so it is reset along
    // with everything else; a discarded partial frame must never leak into the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_data  <= '0;
            buf_count <= '0;
            buf_trunc <= 1'b0;
            slot_idx  <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < MAX_PKTS; i++) begin
                if (slot_idx == CW'(i))
                    buf_data[(MAX_PKTS-1-i)*PKT_W +: PKT_W] <= pkt_data;
            end
            slot_idx <= slot_idx + CW'(1);
            if (close) begin
                buf_count <= slot_idx + CW'(1);
                buf_trunc <= ~pkt_last;
            end
        end else if (handshake) begin
            buf_data  <= '0;
            buf_count <= '0;
            buf_trunc <= 1'b0;
            slot_idx  <= '0;
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pkt_frame_assembler.sv
// Directed self-checking bench for pkt_frame_assembler: reset, full/short/truncated
// frames, backpressure, mid-frame reset and a 256-frame counter wrap with idle gaps.
module tb_pkt_frame_assembler;

    logic        clock = 1'b0;
    logic        reset;
    logic        pkt_valid;
    logic [3:0]  pkt_data;
    logic        pkt_last;
    logic        pkt_ready;
    logic        buf_valid;
    logic [15:0] buf_data;
    logic [2:0]  buf_count;
    logic        buf_trunc;
    logic        out_ready;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_frame_assembler #(.PKT_W(4), .MAX_PKTS(4), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_last  (pkt_last),
        .pkt_ready (pkt_ready),
        .buf_valid (buf_valid),
        .buf_data  (buf_data),
        .buf_count (buf_count),
        .buf_trunc (buf_trunc),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, where outputs are sampled and inputs change.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one packet and return just after the edge that accepts it.
    task automatic send(input logic [3:0] d, input logic last);
        int waited = 0;
        pkt_valid = 1'b1;
        pkt_data  = d;
        pkt_last  = last;
        while (!pkt_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!pkt_ready) check("send_timeout", 32'd0, 32'd1);
        step();
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] data,
                               input logic [2:0] cnt, input logic trunc);
        check({tag, "_valid"}, 32'(buf_valid), 32'd1);
        check({tag, "_data"},  32'(buf_data),  32'(data));
        check({tag, "_count"}, 32'(buf_count), 32'(cnt));
        check({tag, "_trunc"}, 32'(buf_trunc), 32'(trunc));
    endtask

    initial begin
        logic [3:0] d;
        logic [7:0] exp_cnt;
        int         gap;

        reset     = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = 4'h0;
        pkt_last  = 1'b0;
        out_ready = 1'b1;
        #1;

        // Reset held 2 cycles with a packet offered: nothing may be captured.
        reset     = 1'b1;
        pkt_valid = 1'b1;
        pkt_data  = 4'hF;
        pkt_last  = 1'b1;
        step();
        step();
        reset     = 1'b0;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        check("rst_ready",  32'(pkt_ready), 32'd1);
        check("rst_valid",  32'(buf_valid), 32'd0);
        check("rst_data",   32'(buf_data),  32'h0000);
        check("rst_count",  32'(buf_count), 32'd0);
        check("rst_trunc",  32'(buf_trunc), 32'd0);
        check("rst_fcnt",   32'(frame_cnt), 32'd0);
        step();
        check("rst_nocap",  32'(buf_data),  32'h0000);

        // Full frame closed by last on the 4th packet.
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'hA, 1'b1);
        check_frame("full", 16'h123A, 3'd4, 1'b0);
        check("full_fcnt_pre", 32'(frame_cnt), 32'd0);
        step();
        check("full_valid_1cyc", 32'(buf_valid), 32'd0);
        check("full_clear",      32'(buf_data),  32'h0000);
        check("full_fcnt",       32'(frame_cnt), 32'd1);
        check("full_ready",      32'(pkt_ready), 32'd1);

        // Short frame held under backpressure; offered packets are ignored in HOLD.
        out_ready = 1'b0;
        send(4'h5, 1'b0);
        send(4'hC, 1'b1);
        pkt_valid = 1'b1;
        pkt_data  = 4'hF;
        pkt_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_frame("bp", 16'h5C00, 3'd2, 1'b0);
            check("bp_ready", 32'(pkt_ready), 32'd0);
            if (c == 4) out_ready = 1'b1;
            step();
        end
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        check("bp_released", 32'(buf_valid), 32'd0);
        check("bp_clear",    32'(buf_data),  32'h0000);
        check("bp_count",    32'(buf_count), 32'd0);
        check("bp_fcnt",     32'(frame_cnt), 32'd2);
        check("bp_ready_after", 32'(pkt_ready), 32'd1);
        step();
        check("bp_bubble", 32'(buf_data), 32'h0000);

        // Truncation: 4 packets without last, 5th waits through HOLD and opens the next frame.
        out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        check_frame("trunc", 16'h1234, 3'd4, 1'b1);
        pkt_valid = 1'b1;
        pkt_data  = 4'h5;
        pkt_last  = 1'b1;
        step();
        step();
        check_frame("trunc_hold", 16'h1234, 3'd4, 1'b1);
        out_ready = 1'b1;
        step();
        check("trunc_fcnt",  32'(frame_cnt), 32'd3);
        check("trunc_clear", 32'(buf_data),  32'h0000);
        check("trunc_ready", 32'(pkt_ready), 32'd1);
        step();
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        check_frame("trunc_next", 16'h5000, 3'd1, 1'b0);
        step();
        check("trunc_next_fcnt", 32'(frame_cnt), 32'd4);

        // Reset mid-frame discards the partial frame and the counter.
        send(4'h7, 1'b0);
        send(4'h8, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_data",  32'(buf_data),  32'h0000);
        check("mid_rst_fcnt",  32'(frame_cnt), 32'd0);
        check("mid_rst_ready", 32'(pkt_ready), 32'd1);
        send(4'h9, 1'b1);
        check_frame("mid_rst", 16'h9000, 3'd1, 1'b0);
        step();
        check("mid_rst_fcnt1", 32'(frame_cnt), 32'd1);

        // 256 single-packet frames from a fresh reset with random idle gaps.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            d = 4'($urandom_range(1, 15));
            send(d, 1'b1);
            check_frame("wrap", {d, 12'h000}, 3'd1, 1'b0);
            check("wrap_fcnt_hold", 32'(frame_cnt), 32'(exp_cnt));
            step();
            exp_cnt = exp_cnt + 8'd1;
            check("wrap_fcnt", 32'(frame_cnt), 32'(exp_cnt));
        end
        check("wrap_zero", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pkt_frame_assembler.md
# pkt_frame_assembler

Collects a stream of narrow data packets into one wide buffer word and presents it to the downstream data-buffer stage with a valid/ready handshake. The frame closes on the packet flagged last, or when the buffer is full. Packets are stored in reversed arrival order: the first packet lands in the most-significant slot. The block sits directly upstream of the data-buffer consumer and replaces ad-hoc "last packet received" event signalling with a synchronous, registered interface.

## Interface
- PKT_W, 4, width of one data packet in bits
- MAX_PKTS, 4, buffer depth in packets; the buffer word is PKT_W*MAX_PKTS bits
- CNT_W, 8, width of the completed-frame counter
- clock  input  1  single clock; all state changes on the posedge
- reset  input  1  synchronous, active-high reset, sampled on the posedge of clock
- pkt_valid  input  1  upstream packet present
- pkt_data  input  PKT_W  packet payload
- pkt_last  input  1  qualifies pkt_data as the final packet of the frame
- pkt_ready  output  1  block can accept a packet this cycle
- buf_valid  output  1  assembled frame available
- buf_data  output  PKT_W*MAX_PKTS  assembled frame, first packet in the MS slot
- buf_count  output  clog2(MAX_PKTS+1)  number of packets in the presented frame
- buf_trunc  output  1  frame was force-closed at MAX_PKTS without pkt_last
- out_ready  input  1  downstream accepts the frame
- frame_cnt  output  CNT_W  frames delivered since reset, wraps modulo 2^CNT_W

## Operation
- States:
  - COLLECT: accepting packets; pkt_ready=1, buf_valid=0.
  - HOLD: frame presented; pkt_ready=0, buf_valid=1.
- Packet accept: pkt_valid && pkt_ready at a posedge.
- Accepted packet index k (0-based within the frame) is written to buf_data[(MAX_PKTS-1-k)*PKT_W +: PKT_W]. Slots that are never filled stay 0.
- COLLECT -> HOLD when an accepted packet has pkt_last=1. Then buf_count=k+1 and buf_trunc=0.
- COLLECT -> HOLD when k=MAX_PKTS-1 is accepted with pkt_last=0. Then buf_count=MAX_PKTS and buf_trunc=1.
  - If pkt_last=1 on the MAX_PKTS-th packet, buf_trunc=0.
- HOLD -> COLLECT on buf_valid && out_ready. On that edge:
  - buf_data, buf_count, buf_trunc and the slot index clear to 0.
  - frame_cnt increments; from all-ones it wraps to 0.
- In HOLD, pkt_valid is ignored; upstream must hold its packet until pkt_ready.
- pkt_last on a non-accepted cycle has no effect.
- X/Z on pkt_data is stored as-is; no sanitising.
- Reset (any state, including mid-frame or during HOLD):
  - state=COLLECT
  - pkt_ready=1 (the first cycle after reset)
  - buf_valid=0, buf_data=0, buf_count=0, buf_trunc=0, frame_cnt=0
  - any partial frame is discarded
- Reset has priority over every handshake in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from input to output.
  - pkt_ready is decoded from the state register only.
  - buf_* are driven from registers.
- Latency: if the closing packet is accepted at edge N, buf_valid=1 and buf_data is final in the cycle after N.
- HOLD lasts at least 1 cycle. If out_ready=1 continuously, buf_valid is high for exactly 1 cycle.
- After the frame handshake at edge M, pkt_ready=1 from the cycle after M. There is one bubble cycle between frames: no packet is accepted on edge M.
- A single-packet frame is legal: one packet with pkt_last=1 gives buf_count=1.
- Maximum throughput is MAX_PKTS packets per MAX_PKTS+1 cycles.
- buf_data, buf_count and buf_trunc are stable for the whole of HOLD.

## Test plan
- **Reset:** assert reset for 2 cycles with pkt_valid=1 -> pkt_ready=1, buf_valid=0, buf_data=16'h0000, frame_cnt=0; nothing is captured.
- **Full frame with last:** send 4'h1, 4'h2, 4'h3, 4'hA (last) on consecutive cycles, out_ready=1 -> one cycle later buf_data=16'h123A, buf_count=4, buf_trunc=0; buf_valid high for 1 cycle; frame_cnt=1.
- **Short frame with backpressure:** send 4'h5, 4'hC (last) with out_ready=0 for 5 cycles -> buf_data=16'h5C00, buf_count=2; buf_valid held 5 cycles; pkt_ready=0 and pkt_valid ignored throughout; on out_ready=1, buf_data clears and frame_cnt increments.
- **Truncation:** send 4'h1..4'h5 with no last -> first frame is 16'h1234 with buf_trunc=1; 4'h5 is held off during HOLD and becomes packet 0 of the next frame.
- **Reset mid-operation:** after 2 packets accepted, pulse reset for 1 cycle, then send 4'h9 (last) -> buf_data=16'h9000, buf_count=1; no remnant of the earlier packets.
- **Wrap and gaps:** deliver 256 single-packet frames with random pkt_valid gaps -> frame_cnt wraps to 0 on the 256th handshake; a scoreboard matches every frame.
